// File: rtl/coa_pkg.sv
// rtl/coa_pkg.sv - shared COA datapath package: FSM state encoding and default adder geometry
package coa_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CHUNK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } coa_state_e;

    // Chunk counter width; a one-chunk run still needs a 1-bit counter.
    function automatic int cnt_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/chunk_fulladder.sv
// rtl/chunk_fulladder.sv - combinational CHUNK-bit ripple of full-adder cells
module chunk_fulladder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle adder summing CHUNK bits per clock under start/busy/done
// Optional subtract mode: define SERIAL_CHUNK_ADDER_SUB_EN to add the sub input.
module serial_chunk_adder
    import coa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    coa_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0] chunk_s;
    logic             chunk_ci;
    logic             chunk_co;
    logic [WIDTH-1:0] b_cap;
    logic             cin_cap;

    // The captured carry-in feeds chunk 0 so the visible carry stays put until E1.
    assign chunk_ci = (cnt_q == '0) ? cin_q : carry_q;

    chunk_fulladder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x (a_q[CHUNK-1:0]),
        .y (b_q[CHUNK-1:0]),
        .ci(chunk_ci),
        .s (chunk_s),
        .co(chunk_co)
    );

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    assign b_cap   = sub ? ~b : b;
    assign cin_cap = sub ? 1'b1 : cin;
`else
    assign b_cap   = b;
    assign cin_cap = cin;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_cap;
                    cin_d   = cin_cap;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_co;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - self-checking bench for serial_chunk_adder (WIDTH=16, CHUNK=4)
module tb_serial_chunk_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_carry;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;
    logic             done;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        .sub  (sub),
`endif
        .sum  (sum),
        .carry(carry),
        .busy (busy),
        .done (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge E0.
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic tsub);
        a     = ta;
        b     = tb_;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Walks forward from the current sample until done; edges counts from the start edge.
    task automatic wait_done(input int e_init, output int edges, output int bcnt);
        edges = e_init;
        bcnt  = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) check("busy_and_done_exclusive", 32'(busy & done), 32'd0);
            if (done) break;
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    vec_t vecs[$];
    int   edges;
    int   bcnt;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;

        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1});
        vecs.push_back('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0});
        vecs.push_back('{16'hABCD, 16'h5432, 1'b1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0});
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_sum",   32'(sum),   32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            check("vec_busy_after_start", 32'(busy), 32'd1);
            wait_done(1, edges, bcnt);
            check($sformatf("vec%0d_latency", i), 32'(edges), 32'(NCH + 1));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(NCH));
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_sum_hold", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_carry_hold", i), 32'(carry), 32'(vecs[i].exp_carry));
        end

        // start during RUN must not recapture operands
        launch(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a     = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'h0000;
        wait_done(3, edges, bcnt);
        check("ignore_latency", 32'(edges), 32'(NCH + 1));
        check("ignore_busy_cycles", 32'(bcnt + 2), 32'(NCH));
        check("ignore_sum", 32'(sum), 32'h2345);
        check("ignore_carry", 32'(carry), 32'd0);
        @(posedge clk);
        #1;

        // asynchronous reset mid-run, then a fresh run
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_sum",   32'(sum),   32'd0);
        check("midrst_carry", 32'(carry), 32'd0);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        wait_done(1, edges, bcnt);
        check("postrst_latency", 32'(edges), 32'(NCH + 1));
        check("postrst_sum", 32'(sum), 32'h0007);
        check("postrst_carry", 32'(carry), 32'd0);
        @(posedge clk);
        #1;

        // back-to-back: start accepted in the DONE cycle
        launch(16'h0001, 16'h0002, 1'b0, 1'b0);
        wait_done(1, edges, bcnt);
        check("b2b_first_sum", 32'(sum), 32'h0003);
        a     = 16'h8000;
        b     = 16'h8000;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_no_gap_busy", 32'(busy), 32'd1);
        check("b2b_no_gap_done", 32'(done), 32'd0);
        check("b2b_sum_stable_at_e0", 32'(sum), 32'h0003);
        wait_done(1, edges, bcnt);
        check("b2b_latency", 32'(edges), 32'(NCH + 1));
        check("b2b_sum", 32'(sum), 32'h0000);
        check("b2b_carry", 32'(carry), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
